// File: rtl/int_sqrt_pkg.sv
// rtl/int_sqrt_pkg.sv - shared sizing helpers for the integer square-root unit
//
// Purpose: width arithmetic shared by int_sqrt and sqrt_stage so both agree
//          on root and remainder sizes for any operand width.
// Ports:   none (package).

package int_sqrt_pkg;

  // Operand width used when the top is instantiated without overrides.
  localparam int DEFAULT_WIDTH = 20;

  // The partial remainder needs two bits beyond the root width: after a
  // stage it is bounded by 2*root, and before the subtract it has been
  // shifted left by one bit-pair.
  localparam int REM_EXTRA = 2;

  // Number of root bits (one per operand bit-pair, odd widths rounded up).
  function automatic int root_width(input int w);
    return (w + 1) / 2;
  endfunction

  // Width of the partial remainder carried between stages.
  function automatic int rem_width(input int w);
    return root_width(w) + REM_EXTRA;
  endfunction

endpackage

// File: rtl/sqrt_stage.sv
// rtl/sqrt_stage.sv - one restoring radix-4 square-root step
//
// Purpose: consumes the next operand bit-pair, tries to subtract
//          (4*root + 1) from the shifted remainder, and emits one root bit.
// Ports:
//   rem_in   partial remainder from the previous stage (RW+2 bits)
//   root_in  partial root from the previous stage (RW bits, LSB-aligned)
//   pair     next two operand bits, MSB-first order
//   rem_out  updated remainder (RW+2 bits)
//   root_bit new root bit; 1 when the trial subtraction did not go negative

module sqrt_stage
  import int_sqrt_pkg::*;
#(
  parameter int RW = root_width(DEFAULT_WIDTH)
) (
  input  logic [RW+REM_EXTRA-1:0] rem_in,
  input  logic [RW-1:0]           root_in,
  input  logic [1:0]              pair,
  output logic [RW+REM_EXTRA-1:0] rem_out,
  output logic                    root_bit
);

  localparam int REMW = RW + REM_EXTRA;

  // Work two bits wider than the stored remainder so the shift never
  // truncates, even though in practice the top bits of rem_in are zero.
  logic [REMW+1:0] shifted;
  logic [REMW+1:0] trial;
  logic [REMW+1:0] diff;

  assign shifted  = {rem_in, pair};
  assign trial    = {2'b00, root_in, 2'b01};
  assign diff     = shifted - trial;
  assign root_bit = (shifted >= trial);

  // Restoring step: keep the difference only when it stayed non-negative.
  assign rem_out  = root_bit ? REMW'(diff) : REMW'(shifted);

endmodule

// File: rtl/int_sqrt.sv
// rtl/int_sqrt.sv - floor(sqrt(a)) with a zero-latency result and a registered copy
//
// Purpose: combinational integer square root of an unsigned or
//          two's-complement operand, plus an optional captured result.
// Ports:
//   clk        clock for the registered path only
//   reset      asynchronous, active-high; clears root_q and out_valid
//   a          radicand, WIDTH bits
//   root       combinational floor(sqrt(|a|)), (WIDTH+1)/2 bits
//   in_valid   capture strobe for the registered path
//   root_q     root captured on the last posedge with in_valid high
//   out_valid  in_valid delayed by one clock

module int_sqrt
  import int_sqrt_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int TC_MODE = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             a,
  output logic [root_width(WIDTH)-1:0] root,
  input  logic                         in_valid,
  output logic [root_width(WIDTH)-1:0] root_q,
  output logic                         out_valid
);

  localparam int RW   = root_width(WIDTH);
  localparam int AW   = 2 * RW;
  localparam int REMW = rem_width(WIDTH);

  // Effective operand magnitude. In two's-complement mode negatives are
  // negated as an unsigned WIDTH-bit value, so the most negative input
  // becomes 2^(WIDTH-1) rather than overflowing.
  logic [WIDTH-1:0] mag;
  logic [AW-1:0]    op;

  always_comb begin
    mag = a;
    if (TC_MODE != 0 && a[WIDTH-1]) begin
      mag = ~a + 1'b1;
    end
  end

  // Odd widths gain one zero MSB so the operand splits into whole bit-pairs.
  assign op = AW'(mag);

  // Stage i sees the remainder and root produced by stages 0..i-1.
  logic [REMW-1:0] rem_chain  [0:RW];
  logic [RW-1:0]   root_chain [0:RW];
  logic [RW-1:0]   root_bits;

  assign rem_chain[0]  = '0;
  assign root_chain[0] = '0;

  genvar i;
  generate
    for (i = 0; i < RW; i++) begin : g_stage
      sqrt_stage #(
        .RW (RW)
      ) u_stage (
        .rem_in   (rem_chain[i]),
        .root_in  (root_chain[i]),
        .pair     (op[AW-1-2*i -: 2]),
        .rem_out  (rem_chain[i+1]),
        .root_bit (root_bits[i])
      );

      assign root_chain[i+1] = (root_chain[i] << 1) | RW'(root_bits[i]);
    end
  endgenerate

  assign root = root_chain[RW];

  // The final remainder (a - root^2) is not an output of this unit.
  logic unused_final_rem;
  assign unused_final_rem = ^rem_chain[RW];

  // Registered copy; no extra state, so the first edge after reset release
  // captures normally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      root_q    <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        root_q <= root;
      end
    end
  end

endmodule

// File: tb/tb_int_sqrt.sv
// tb/tb_int_sqrt.sv - directed and exhaustive checks for int_sqrt

module tb_int_sqrt;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] a;
  logic [9:0]  root;
  logic        in_valid;
  logic [9:0]  root_q;
  logic        out_valid;

  logic [19:0] a_tc;
  logic [9:0]  root_tc;
  logic [9:0]  root_q_tc;
  logic        out_valid_tc;

  logic [6:0]  a_odd;
  logic [3:0]  root_odd;
  logic [3:0]  root_q_odd;
  logic        out_valid_odd;

  logic        idle_valid = 1'b0;

  int errors = 0;
  int checks = 0;

  int_sqrt #(.WIDTH(20), .TC_MODE(0)) dut (
    .clk(clk), .reset(reset), .a(a), .root(root),
    .in_valid(in_valid), .root_q(root_q), .out_valid(out_valid)
  );

  int_sqrt #(.WIDTH(20), .TC_MODE(1)) dut_tc (
    .clk(clk), .reset(reset), .a(a_tc), .root(root_tc),
    .in_valid(idle_valid), .root_q(root_q_tc), .out_valid(out_valid_tc)
  );

  int_sqrt #(.WIDTH(7), .TC_MODE(0)) dut_odd (
    .clk(clk), .reset(reset), .a(a_odd), .root(root_odd),
    .in_valid(idle_valid), .root_q(root_q_odd), .out_valid(out_valid_odd)
  );

  always #50 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; a = 20'd0; a_tc = 20'd0; a_odd = 7'd0;
    @(negedge clk);
    checks++;
    if (root_q !== 10'd0) begin
      errors++; $display("FAIL reset_root_q got=%0d exp=0", root_q);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid);
    end
    checks++;
    if (root !== 10'd0) begin
      errors++; $display("FAIL reset_root_a0 got=%0d exp=0", root);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_boundaries();
    logic [19:0] vin  [9] = '{20'd0, 20'd1, 20'd3, 20'd4, 20'd15, 20'd16,
                              20'd1048575, 20'd1046529, 20'd1046528};
    logic [9:0]  vexp [9] = '{10'd0, 10'd1, 10'd1, 10'd2, 10'd3, 10'd4,
                              10'd1023, 10'd1023, 10'd1022};
    for (int k = 0; k < 9; k++) begin
      a = vin[k];
      #1;
      checks++;
      if (root !== vexp[k]) begin
        errors++; $display("FAIL boundary a=%0d got=%0d exp=%0d", vin[k], root, vexp[k]);
      end
    end
  endtask

  task automatic test_accum();
    logic [19:0] vin  [3] = '{20'd25, 20'd50, 20'd1000000};
    logic [9:0]  vexp [3] = '{10'd5, 10'd7, 10'd1000};
    for (int k = 0; k < 3; k++) begin
      a = vin[k];
      #1;
      checks++;
      if (root !== vexp[k]) begin
        errors++; $display("FAIL accum a=%0d got=%0d exp=%0d", vin[k], root, vexp[k]);
      end
    end
  endtask

  task automatic test_registered();
    @(negedge clk);
    a = 20'd144; in_valid = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (root_q !== 10'd12) begin
      errors++; $display("FAIL reg_capture_root_q got=%0d exp=12", root_q);
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL reg_capture_out_valid got=%b exp=1", out_valid);
    end
    @(negedge clk);
    a = 20'd400; in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (root_q !== 10'd12) begin
      errors++; $display("FAIL reg_hold_root_q got=%0d exp=12", root_q);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reg_hold_out_valid got=%b exp=0", out_valid);
    end
    checks++;
    if (root !== 10'd20) begin
      errors++; $display("FAIL reg_hold_comb_root got=%0d exp=20", root);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    a = 20'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (root_q !== 10'd3 || out_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_first root_q=%0d out_valid=%b exp=3,1", root_q, out_valid);
    end
    @(negedge clk);
    a = 20'd100;
    @(posedge clk); #1;
    checks++;
    if (root_q !== 10'd10 || out_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_second root_q=%0d out_valid=%b exp=10,1", root_q, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    a = 20'd144; in_valid = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (root_q !== 10'd12 || out_valid !== 1'b1) begin
      errors++; $display("FAIL areset_setup root_q=%0d out_valid=%b exp=12,1", root_q, out_valid);
    end
    #20;
    reset = 1'b1;
    #1;
    checks++;
    if (root_q !== 10'd0) begin
      errors++; $display("FAIL areset_root_q got=%0d exp=0", root_q);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL areset_out_valid got=%b exp=0", out_valid);
    end
    checks++;
    if (root !== 10'd12) begin
      errors++; $display("FAIL areset_comb_root got=%0d exp=12", root);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (root_q !== 10'd12 || out_valid !== 1'b1) begin
      errors++; $display("FAIL areset_release root_q=%0d out_valid=%b exp=12,1", root_q, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_tc_mode();
    logic [19:0] vin  [4] = '{20'hFFFF0, 20'hFFFFF, 20'h80000, 20'h7FFFF};
    logic [9:0]  vexp [4] = '{10'd4, 10'd1, 10'd724, 10'd724};
    for (int k = 0; k < 4; k++) begin
      a_tc = vin[k];
      #1;
      checks++;
      if (root_tc !== vexp[k]) begin
        errors++; $display("FAIL tc a=0x%05h got=%0d exp=%0d", vin[k], root_tc, vexp[k]);
      end
    end
  endtask

  task automatic test_odd_width();
    logic [6:0] vin  [4] = '{7'd127, 7'd121, 7'd120, 7'd0};
    logic [3:0] vexp [4] = '{4'd11, 4'd11, 4'd10, 4'd0};
    for (int k = 0; k < 4; k++) begin
      a_odd = vin[k];
      #1;
      checks++;
      if (root_odd !== vexp[k]) begin
        errors++; $display("FAIL odd a=%0d got=%0d exp=%0d", vin[k], root_odd, vexp[k]);
      end
    end
  endtask

  task automatic test_sweep();
    int r = 0;
    int bad = 0;
    int first_bad = -1;
    logic [9:0] first_got = '0;
    for (int v = 0; v < 1048576; v++) begin
      while ((r + 1) * (r + 1) <= v) r++;
      a = v[19:0];
      #1;
      if (root !== r[9:0]) begin
        if (bad == 0) begin
          first_bad = v; first_got = root;
        end
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL sweep bad_count=%0d exp=0 first_a=%0d got=%0d", bad, first_bad, first_got);
    end
  endtask

  initial begin
    test_reset();
    test_boundaries();
    test_accum();
    test_registered();
    test_back_to_back();
    test_async_reset();
    test_tc_mode();
    test_odd_width();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/int_sqrt.md
Name:
int_sqrt

Overview:
- Integer square-root unit: `root = floor(sqrt(a))` on an unsigned (optionally two's-complement) operand.
- Primary result is purely combinational, so a consumer can register it in the same cycle its operand register updates. Example: an L2-norm pipeline feeds a 20-bit accumulator and captures the 10-bit root one cycle later.
- Also provides an optional registered copy of the result with a valid flag.

Parameters:
- WIDTH, 20, operand width in bits; legal range 2..64.
- TC_MODE, 0, 0 = operand unsigned; 1 = operand two's complement, and the root of |a| is returned.

Ports:
- clk  input  1  clock; used only by the registered output path.
- reset  input  1  reset, asynchronous, active-high; clock clk.
- a  input  WIDTH  radicand.
- root  output  (WIDTH+1)/2  combinational floor(sqrt(a)); 10 bits at default.
- in_valid  input  1  capture strobe for the registered path.
- root_q  output  (WIDTH+1)/2  registered root.
- out_valid  output  1  high the cycle after a cycle with in_valid high.

Behaviour:
- root is a pure function of a, with zero latency. It does not depend on clk or reset and must be correct whenever a is stable.
- Result width RW = (WIDTH+1)/2. For odd WIDTH, the operand is zero-extended by one MSB before computation.
- Required result: root*root <= A < (root+1)*(root+1), where A is the effective operand. No rounding; the result is always truncated (floor).
- TC_MODE=0: A = a, unsigned.
- TC_MODE=1, a[WIDTH-1]=1: A = two's-complement negation of a, taken as an unsigned WIDTH-bit value. The most negative value maps to 2^(WIDTH-1).
- Algorithm: restoring digit-by-digit (radix-4). RW stages, each consuming two operand bits MSB-first and producing one root bit, all unrolled combinationally. Internal remainder is RW+2 bits wide.
- Registered path:
  - On reset assertion (asynchronous): root_q = 0, out_valid = 0 immediately.
  - At each posedge clk with reset low: out_valid <= in_valid.
  - If in_valid = 1, root_q <= root. Otherwise root_q holds its value.
- Reset released mid-stream: the first posedge after release behaves normally, with no extra pipeline bubble.
- No X propagation required. With a defined input, the outputs must never be X.
- Boundary values (default WIDTH):
  - a=0 -> 0
  - a=1 -> 1
  - a=3 -> 1
  - a=4 -> 2
  - a=1048575 -> 1023 (max; no overflow)
  - a=1046529 (1023^2) -> 1023
  - a=1046528 -> 1022

Decomposition:
- Package int_sqrt_pkg:
  - function root_width(int w) returning (w+1)/2.
  - localparam constants for remainder width.
- One natural sub-module, sqrt_stage: a single restoring step.
  - Inputs: partial remainder, partial root, next operand bit-pair.
  - Outputs: new remainder and new root bit.
  - int_sqrt instantiates RW copies via generate.
- Registered output logic stays in the top module.

Test Plan:
- Exhaustive sweep, WIDTH=20, TC_MODE=0: every a from 0 to 1048575 -> root equals floor(sqrt(a)) against a reference model. Explicitly check 0->0, 15->3, 16->4, 1048575->1023.
- Accumulated-sum use: a=25 (9+16) -> 5; a=50 -> 7; a=1000000 -> 1000.
- Registered path:
  - Pulse in_valid with a=144 -> next posedge root_q=12, out_valid=1.
  - in_valid low, a=400 -> root_q stays 12, out_valid=0.
- Async reset: with root_q=12 and out_valid=1, raise reset between clock edges -> both go to 0 before the next posedge. Combinational root is unaffected (still reflects a).
- TC_MODE=1, WIDTH=20: a=-16 -> 4; a=-1 -> 1; a=-524288 -> 724; a=524287 -> 724.
- Odd width, WIDTH=7, TC_MODE=0: a=127 -> 11; a=121 -> 11; a=120 -> 10; RW=4.
